// File: rtl/tim_pkg.sv
// tim_pkg: shared timer constants and PWM generator state type
package tim_pkg;
  localparam int TIM_W = 4;
  localparam int TIM_MAX = 2 ** TIM_W - 1;
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_e;
endpackage

// File: rtl/tim_pwm_shadow.sv
// tim_pwm_shadow: double-buffered duty register committed on load strobes
module tim_pwm_shadow
  import tim_pkg::*;
#(
  parameter int W = TIM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W:0]   duty_in,
  input  logic         load,
  output logic [W:0]   duty_act,
  output logic         upd
);
  logic [W:0] duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
  logic       pend_q, pend_d, upd_q, upd_d;
  always_comb begin
    duty_sh_d  = wr ? duty_in : duty_sh_q;
    duty_act_d = load ? duty_sh_q : duty_act_q;
    upd_d      = load && pend_q;
    pend_d     = wr || (pend_q && !load);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      pend_q     <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      pend_q     <= pend_d;
      upd_q      <= upd_d;
    end
  end
  assign duty_act = duty_act_q;
  assign upd      = upd_q;
endmodule

// File: rtl/tim_pwm.sv
// tim_pwm: PWM generator on an upstream timer with buffered duty and one-shot mode
module tim_pwm
  import tim_pkg::*;
#(
  parameter int W  = TIM_W,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tim_en,
  input  logic [W-1:0]  tim,
  input  logic          cfg_wr,
  input  logic [W:0]    cfg_duty,
  input  logic          cfg_oneshot,
  input  logic [CW-1:0] cfg_nper,
  input  logic          start,
  input  logic          stop,
  output logic          pwm,
  output logic          busy,
  output logic          prd,
  output logic          upd,
  output logic          done
);
  state_e        state_q, state_d;
  logic [CW-1:0] nper_q, nper_d, left_q, left_d;
  logic          mode_q, mode_d, pwm_q, pwm_d, prd_q, prd_d, done_q, done_d;
  logic          bnd, load;
  logic [W:0]    duty_act;
  assign bnd = tim_en && (&tim);
  tim_pwm_shadow #(.W(W)) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .wr       (cfg_wr),
    .duty_in  (cfg_duty),
    .load     (load),
    .duty_act (duty_act),
    .upd      (upd)
  );
  always_comb begin
    state_d = state_q;
    nper_d  = nper_q;
    left_d  = left_q;
    mode_d  = mode_q;
    load    = 1'b0;
    prd_d   = 1'b0;
    done_d  = 1'b0;
    pwm_d   = (state_q == RUN || state_q == DRAIN) && ({1'b0, tim} < duty_act);
    case (state_q)
      IDLE: if (start && !stop) begin
        state_d = ARMED;
        mode_d  = cfg_oneshot;
        nper_d  = cfg_nper == '0 ? CW'(1) : cfg_nper;
      end
      ARMED: if (stop) state_d = IDLE;
      else if (bnd) begin
        state_d = RUN;
        load    = 1'b1;
        left_d  = nper_q;
      end
      RUN: if (bnd) begin
        prd_d = 1'b1;
        load  = 1'b1;
        if (mode_q && left_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          left_d  = mode_q ? left_q - CW'(1) : left_q;
          state_d = stop ? DRAIN : RUN;
        end
      end else if (stop) state_d = DRAIN;
      default: if (bnd) begin
        state_d = IDLE;
        prd_d   = 1'b1;
        done_d  = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      nper_q  <= '0;
      left_q  <= '0;
      mode_q  <= 1'b0;
      pwm_q   <= 1'b0;
      prd_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nper_q  <= nper_d;
      left_q  <= left_d;
      mode_q  <= mode_d;
      pwm_q   <= pwm_d;
      prd_q   <= prd_d;
      done_q  <= done_d;
    end
  end
  assign pwm  = pwm_q;
  assign busy = state_q != IDLE;
  assign prd  = prd_q;
  assign done = done_q;
endmodule

// File: tb/tb_tim_pwm.sv
// tb_tim_pwm: randomized self-checking bench against a behavioural PWM model
module tb_tim_pwm;
  localparam int W = 4;
  localparam int CW = 8;
  localparam int TOP = 2 ** W - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tim_en = 1'b0;
  logic [W-1:0] tim = '0;
  logic cfg_wr = 1'b0;
  logic [W:0] cfg_duty = '0;
  logic cfg_oneshot = 1'b0;
  logic [CW-1:0] cfg_nper = '0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic pwm, busy, prd, upd, done;
  int errors = 0;
  int checks = 0;
  int m_ph = 0, m_sh = 0, m_act = 0, m_pend = 0, m_left = 0, m_nper = 0, m_mode = 0;
  int m_pwm = 0, m_prd = 0, m_upd = 0, m_done = 0;
  always #5 clk = ~clk;
  tim_pwm #(.W(W), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .tim_en      (tim_en),
    .tim         (tim),
    .cfg_wr      (cfg_wr),
    .cfg_duty    (cfg_duty),
    .cfg_oneshot (cfg_oneshot),
    .cfg_nper    (cfg_nper),
    .start       (start),
    .stop        (stop),
    .pwm         (pwm),
    .busy        (busy),
    .prd         (prd),
    .upd         (upd),
    .done        (done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask
  task automatic model_step;
    bit bnd;
    bit load;
    bnd  = tim_en && int'(tim) == TOP;
    load = 1'b0;
    if (rst) begin
      {m_ph, m_sh, m_act, m_pend, m_left, m_nper, m_mode} = '0;
      {m_pwm, m_prd, m_upd, m_done} = '0;
      return;
    end
    m_pwm  = (m_ph >= 2 && int'(tim) < m_act) ? 1 : 0;
    m_prd  = 0;
    m_upd  = 0;
    m_done = 0;
    if (m_ph == 0) begin
      if (start && !stop) begin
        m_ph   = 1;
        m_mode = cfg_oneshot;
        m_nper = cfg_nper == 0 ? 1 : int'(cfg_nper);
      end
    end else if (m_ph == 1) begin
      if (stop) m_ph = 0;
      else if (bnd) begin
        m_ph   = 2;
        load   = 1'b1;
        m_left = m_nper;
      end
    end else if (m_ph == 2) begin
      if (bnd) begin
        m_prd = 1;
        load  = 1'b1;
        if (m_mode == 1 && m_left == 1) begin
          m_ph   = 0;
          m_done = 1;
        end else begin
          if (m_mode == 1) m_left--;
          if (stop) m_ph = 3;
        end
      end else if (stop) m_ph = 3;
    end else if (bnd) begin
      m_ph   = 0;
      m_prd  = 1;
      m_done = 1;
    end
    if (load) begin
      m_upd  = m_pend;
      m_act  = m_sh;
      m_pend = 0;
    end
    if (cfg_wr) begin
      m_sh   = int'(cfg_duty);
      m_pend = 1;
    end
  endtask
  initial begin
    for (int c = 0; c < 8000; c++) begin
      int r;
      @(negedge clk);
      if (tim_en) tim = tim + 1'b1;
      if (c > 0) begin
        chk("pwm", 32'(pwm), 32'(m_pwm));
        chk("busy", 32'(busy), 32'(m_ph != 0));
        chk("prd", 32'(prd), 32'(m_prd));
        chk("upd", 32'(upd), 32'(m_upd));
        chk("done", 32'(done), 32'(m_done));
      end
      rst = c < 2 || $urandom_range(0, 499) == 0;
      case (c / 2000)
        0: tim_en = 1'b1;
        1: tim_en = 1'($urandom_range(0, 1));
        2: tim_en = $urandom_range(0, 7) == 0;
        default: tim_en = 1'b1;
      endcase
      r = int'($urandom_range(0, 3));
      cfg_wr      = $urandom_range(0, 9) == 0;
      cfg_duty    = r == 0 ? '0 : r == 1 ? (W+1)'(TOP + 1) : (W+1)'($urandom_range(0, TOP + 1));
      cfg_oneshot = 1'($urandom_range(0, 1));
      cfg_nper    = CW'($urandom_range(0, 3));
      start       = $urandom_range(0, 5) == 0;
      stop        = $urandom_range(0, 59) == 0;
      model_step;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tim_pwm.md
Name: tim_pwm

Overview:
- Downstream consumer of the free-running W-bit timer count (tim, qualified by the same en).
- Generates a PWM waveform with duty cycle double-buffered at timer wrap, in continuous or N-period one-shot mode.
- Period = 2^W enabled timer steps. Provides period/done/update event pulses to control logic.

Parameters:
W, 4, timer count width; must match the upstream counter width
CW, 8, one-shot period-count width

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  synchronous reset, active-high
tim_en  in  1  timer step qualifier; upstream count advances by 1 on each clk with tim_en=1 and wraps 2^W-1 -> 0
tim  in  W  upstream timer count
cfg_wr  in  1  write cfg_duty into shadow register
cfg_duty  in  W+1  duty in timer steps, 0..2^W
cfg_oneshot  in  1  sampled at start: 1 = one-shot, 0 = continuous
cfg_nper  in  CW  sampled at start: one-shot period count; 0 treated as 1
start  in  1  arm the generator (honoured in IDLE only)
stop  in  1  graceful stop request
pwm  out  1  PWM output, registered
busy  out  1  state != IDLE
prd  out  1  1-cycle pulse at each boundary in RUN/DRAIN
upd  out  1  1-cycle pulse when a pending shadow duty is committed
done  out  1  1-cycle pulse on return to IDLE from RUN/DRAIN

Behaviour:
- Boundary event: bnd = tim_en && tim == 2^W-1. It fires exactly once per timer wrap; a stalled tim_en never creates a duplicate.
- Reset state: IDLE, pwm=0, prd=0, upd=0, done=0, duty_sh=0, duty_act=0, pend=0, periods_left=0, mode=0.
- Shadow register:
  - cfg_wr sets duty_sh=cfg_duty and pend=1 in any state.
  - On a load event (ARMED->RUN, or bnd in RUN), duty_act <= duty_sh. If pend was 1, upd pulses and pend clears.
  - cfg_wr in the same cycle as a load event: the load uses the old duty_sh. The new value stays pending until the next bnd.
- pwm register:
  - In RUN/DRAIN: pwm <= (tim < duty_act), compared as an unsigned W+1-bit value. pwm therefore lags tim by exactly 1 clk.
  - duty_act=0 gives constant 0. duty_act=2^W gives constant 1.
  - In IDLE/ARMED: pwm <= 0.
- FSM:
  - IDLE: start && !stop -> ARMED, latching mode=cfg_oneshot and nper=max(cfg_nper,1). start and stop together: stay IDLE.
  - ARMED: stop -> IDLE (no done pulse). bnd -> RUN, with load event and periods_left=nper. No prd pulse on this bnd.
  - RUN, on bnd: prd=1 and load event.
    - If mode is one-shot and periods_left==1 -> IDLE with done=1. Otherwise decrement periods_left (one-shot only).
    - stop with no bnd -> DRAIN.
    - stop together with bnd: the bnd is processed first. If it did not exit to IDLE, go to DRAIN.
  - DRAIN: pwm keeps running, no duty loads. bnd -> IDLE with prd=1, done=1. Further stop/start is ignored.
- start in any state other than IDLE is ignored. stop in IDLE is ignored.
- tim_en low: no bnd and no state progress. pwm keeps comparing the held tim value.
- rst mid-operation: next cycle all reset values apply, including pwm=0 and pending updates discarded.
- Never-enabled timer: the FSM stays ARMED indefinitely; this is legal.

Decomposition:
- Shared package tim_pkg holds:
  - state typedef {IDLE, ARMED, RUN, DRAIN} (2-bit encoding);
  - TIM_W default constant (4), shared with the timer counter;
  - helper constant TIM_MAX = 2^TIM_W-1.
- One natural sub-module: tim_pwm_shadow (duty_sh/duty_act/pend/upd logic, driven by cfg_wr and load strobe).
- FSM, period counter and pwm compare stay in the top.

Test Plan:
- Reset then cfg_wr duty=5, start, tim_en=1 constant with tim counting 0..15 -> first bnd at tim=15 enters RUN; pwm=1 for the 5 clks after tim=0..4, then 0 for 11 clks; prd every 16 clks; upd pulses once, on the RUN entry.
- Continuous, duty 5, cfg_wr duty=12 at tim=7 -> current period unchanged (5 high); next period 12 high; upd pulse coincident with the bnd at tim=15. cfg_wr exactly at tim=15 -> applied one period later.
- duty=0 -> pwm constantly 0. duty=16 -> pwm constantly 1 through RUN, no glitch across wrap. In both cases prd still every 16 clks.
- One-shot, cfg_nper=3, duty=8 -> exactly 3 prd pulses after RUN entry; done coincident with the 3rd; busy low next cycle; pwm 0 afterwards. cfg_nper=0 -> 1 period.
- Continuous run, stop at tim=6 with tim_en toggling 1/0 -> DRAIN; pwm finishes the period at half rate (each tim value held 2 clks); IDLE with done+prd on the bnd. Same cycle start+stop in IDLE -> stays IDLE.
- rst asserted 1 clk mid-RUN with pwm=1 -> next clk pwm=0, busy=0, duty_act=0, pend=0. A subsequent start without cfg_wr runs with duty 0 (pwm constant 0).
